// File: rtl/lc3_int_ctrl_if.sv
// Interrupt controller bus: device lines, config port and the INT/INTV handshake
// toward the LC-3 control FSM.
interface lc3_int_ctrl_if #(
  parameter int NUM_SRC = 8
);
  logic [NUM_SRC-1:0] irq_in;
  logic [2:0]         cpu_prio;
  logic               int_ack;
  logic               int_done;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [15:0]        cfg_wdata;
  logic [15:0]        cfg_rdata;
  logic               int_req;
  logic [7:0]         int_vec;
  logic [2:0]         int_prio;
  logic               dbg_state;

  // Handshake: once int_req rises, int_vec/int_prio stay stable until the cycle
  // int_ack is high (consumed) or the request is withdrawn; int_ack without
  // int_req is ignored. int_done marks one RTI completion.
  modport slave (
    input  irq_in, cpu_prio, int_ack, int_done, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata, int_req, int_vec, int_prio, dbg_state
  );

  modport master (
    output irq_in, cpu_prio, int_ack, int_done, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata, int_req, int_vec, int_prio, dbg_state
  );
endinterface

// File: rtl/lc3_int_ctrl.sv
// Priority interrupt controller feeding INT/INTV of the LC-3 control FSM, with
// edge capture, programmable per-source priority and an in-service nesting stack.
module lc3_int_ctrl #(
  parameter int         NUM_SRC  = 8,
  parameter logic [7:0] VEC_BASE = 8'h80
) (
  input  logic          clk,
  input  logic          rst,
  lc3_int_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [2:0]         src_prio_q [NUM_SRC];
  logic [2:0]         src_prio_d [NUM_SRC];
  logic [2:0]         stack_q [7];
  logic [2:0]         stack_d [7];
  logic [2:0]         depth_q, depth_d;
  logic [2:0]         win_q, win_d;
  logic               int_req_q, int_req_d;
  logic [7:0]         int_vec_q, int_vec_d;
  logic [2:0]         int_prio_q, int_prio_d;

  logic [2:0]         top_prio;
  logic [NUM_SRC-1:0] eligible;
  logic               any_elig;
  logic [2:0]         best_idx;
  logic [2:0]         best_prio;
  logic [NUM_SRC-1:0] pending_clr;
  logic               pop;
  logic [2:0]         depth_pop;
  logic               unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata[14:8];

  assign top_prio = (depth_q == 3'd0) ? 3'd0 : stack_q[depth_q - 3'd1];

  // Arbitration: ascending scan with strict '>' keeps the lowest index on ties.
  always_comb begin
    any_elig  = 1'b0;
    best_idx  = 3'd0;
    best_prio = 3'd0;
    eligible  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = pending_q[i] && enable_q[i] &&
                    (src_prio_q[i] > bus.cpu_prio) && (src_prio_q[i] > top_prio);
      if (eligible[i] && (!any_elig || src_prio_q[i] > best_prio)) begin
        any_elig  = 1'b1;
        best_idx  = 3'(i);
        best_prio = src_prio_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    src_prio_d  = src_prio_q;
    stack_d     = stack_q;
    win_d       = win_q;
    int_req_d   = int_req_q;
    int_vec_d   = int_vec_q;
    int_prio_d  = int_prio_q;
    pending_clr = '0;
    pop         = bus.int_done && (depth_q != 3'd0);
    depth_pop   = depth_q - {2'b00, pop};
    depth_d     = depth_pop;

    if (bus.cfg_we && bus.cfg_addr == 4'hE)
      pending_clr = bus.cfg_wdata[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.cfg_we && bus.cfg_addr == 4'(i)) begin
        enable_d[i]   = bus.cfg_wdata[15];
        src_prio_d[i] = bus.cfg_wdata[2:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          win_d      = best_idx;
          int_vec_d  = VEC_BASE + {5'b00000, best_idx};
          int_prio_d = best_prio;
          int_req_d  = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        // Pop happens before push, so ack+done in one cycle replaces the top.
        if (bus.int_ack) begin
          pending_clr[win_q] = 1'b1;
          stack_d[depth_pop] = int_prio_q;
          depth_d            = depth_pop + 3'd1;
          int_req_d          = 1'b0;
          state_d            = S_IDLE;
        end else if (!eligible[win_q]) begin
          int_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh edge wins over any clear in the same cycle.
    pending_d = (pending_q & ~pending_clr) | (bus.irq_in & ~irq_prev_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      irq_prev_q <= '0;
      enable_q   <= '0;
      depth_q    <= 3'd0;
      win_q      <= 3'd0;
      int_req_q  <= 1'b0;
      int_vec_q  <= 8'd0;
      int_prio_q <= 3'd0;
      for (int i = 0; i < NUM_SRC; i++) src_prio_q[i] <= 3'd0;
      for (int i = 0; i < 7; i++) stack_q[i] <= 3'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= bus.irq_in;
      enable_q   <= enable_d;
      depth_q    <= depth_d;
      win_q      <= win_d;
      int_req_q  <= int_req_d;
      int_vec_q  <= int_vec_d;
      int_prio_q <= int_prio_d;
      src_prio_q <= src_prio_d;
      stack_q    <= stack_d;
    end
  end

  always_comb begin
    bus.cfg_rdata = 16'h0000;
    if (bus.cfg_addr == 4'hE)
      bus.cfg_rdata = 16'(pending_q);
    else if (bus.cfg_addr == 4'hF)
      bus.cfg_rdata = {int_req_q, 4'b0000, depth_q, 5'b00000, top_prio};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.cfg_addr == 4'(i))
        bus.cfg_rdata = {enable_q[i], 12'h000, src_prio_q[i]};
    end
  end

  assign bus.int_req   = int_req_q;
  assign bus.int_vec   = int_vec_q;
  assign bus.int_prio  = int_prio_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Bench for lc3_int_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of pending bits, config and nesting.
module tb_lc3_int_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lc3_int_ctrl_if #(.NUM_SRC(8)) bus ();

  lc3_int_ctrl #(.NUM_SRC(8), .VEC_BASE(8'h80)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  bit [7:0] m_pend, m_prev, m_en;
  int       m_sprio [8];
  int       m_stack [$];
  bit       m_req;
  int       m_win;
  int       m_vprio;

  bit [7:0] cur_irq = 8'h00;
  bit [2:0] cur_cp  = 3'd0;

  function automatic void m_reset();
    m_pend = 0; m_prev = 0; m_en = 0;
    for (int i = 0; i < 8; i++) m_sprio[i] = 0;
    m_stack.delete();
    m_req = 0; m_win = 0; m_vprio = 0;
  endfunction

  function automatic int m_top();
    return (m_stack.size() == 0) ? 0 : m_stack[$];
  endfunction

  function automatic bit m_elig(int i, int cp);
    return m_pend[i] && m_en[i] && (m_sprio[i] > cp) && (m_sprio[i] > m_top());
  endfunction

  function automatic logic [15:0] m_read(int addr);
    if (addr < 8)   return {m_en[addr], 12'h000, 3'(m_sprio[addr])};
    if (addr == 14) return {8'h00, m_pend};
    if (addr == 15) return {m_req, 4'b0000, 3'(m_stack.size()), 5'b00000, 3'(m_top())};
    return 16'h0000;
  endfunction

  function automatic void m_step(bit [7:0] irq, int cp, bit ack, bit done,
                                 bit we, int addr, bit [15:0] wd);
    bit [7:0] clr = 8'h00;
    int best = -1;
    int bp = -1;
    bit el_win = m_req ? m_elig(m_win, cp) : 1'b0;
    for (int i = 0; i < 8; i++)
      if (m_elig(i, cp) && m_sprio[i] > bp) begin best = i; bp = m_sprio[i]; end
    if (we && addr == 14) clr = wd[7:0];
    if (done && m_stack.size() > 0) void'(m_stack.pop_back());
    if (m_req) begin
      if (ack) begin
        clr[m_win] = 1'b1;
        m_stack.push_back(m_vprio);
        m_req = 0;
      end else if (!el_win) begin
        m_req = 0;
      end
    end else if (best >= 0) begin
      m_req = 1; m_win = best; m_vprio = bp;
    end
    m_pend = (m_pend & ~clr) | (irq & ~m_prev);
    m_prev = irq;
    if (we && addr < 8) begin
      m_en[addr]    = wd[15];
      m_sprio[addr] = int'(wd[2:0]);
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives one cycle, steps the model, ends at the next falling edge.
  task automatic step(input bit ack, input bit done, input bit we,
                      input bit [3:0] addr, input bit [15:0] wd);
    bus.irq_in    = cur_irq;
    bus.cpu_prio  = cur_cp;
    bus.int_ack   = ack;
    bus.int_done  = done;
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = wd;
    #1;
    check("rdata", bus.cfg_rdata, m_read(int'(addr)));
    m_step(cur_irq, int'(cur_cp), ack, done, we, int'(addr), wd);
    @(negedge clk);
    check("int_req", 16'(bus.int_req), 16'(m_req));
    if (m_req) begin
      check("int_vec", 16'(bus.int_vec), 16'(8'(8'h80 + m_win)));
      check("int_prio", 16'(bus.int_prio), 16'(m_vprio));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'hF, 16'h0000);
  endtask

  task automatic cfg_write(input bit [3:0] addr, input bit [15:0] wd);
    step(1'b0, 1'b0, 1'b1, addr, wd);
  endtask

  task automatic read_chk(input string tag, input bit [3:0] addr, input logic [15:0] exp);
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = addr;
    #1;
    check(tag, bus.cfg_rdata, exp);
  endtask

  initial begin
    int n_ack;
    bit ack;
    bus.irq_in = '0; bus.cpu_prio = '0; bus.int_ack = 1'b0; bus.int_done = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_req", 16'(bus.int_req), 16'h0);
    check("rst_vec", 16'(bus.int_vec), 16'h0);
    check("rst_prio", 16'(bus.int_prio), 16'h0);
    read_chk("rst_status", 4'hF, 16'h0000);
    read_chk("rst_src0", 4'h0, 16'h0000);
    rst = 1'b1;

    // Single source, best-case latency, ack and nesting status.
    cfg_write(4'h2, 16'h8004);
    cur_irq = 8'h04;
    step(0, 0, 0, 4'hE, 0);
    check("t1_lat_k", 16'(bus.int_req), 16'h0);
    step(0, 0, 0, 4'hE, 0);
    check("t1_req", 16'(bus.int_req), 16'h1);
    check("t1_vec", 16'(bus.int_vec), 16'h0082);
    check("t1_prio", 16'(bus.int_prio), 16'h0004);
    step(1, 0, 0, 4'hF, 0);
    read_chk("t1_pend", 4'hE, 16'h0000);
    read_chk("t1_status", 4'hF, 16'h0104);
    cur_irq = 8'h00;
    step(0, 1, 0, 4'hF, 0);

    // Priority ordering and in-service masking.
    cur_cp = 3'd2;
    cfg_write(4'h1, 16'h8003);
    cfg_write(4'h5, 16'h8006);
    cur_irq = 8'h22;
    idle(2);
    check("t2_vec5", 16'(bus.int_vec), 16'h0085);
    step(1, 0, 0, 4'hF, 0);
    idle(2);
    check("t2_blocked", 16'(bus.int_req), 16'h0);
    step(0, 1, 0, 4'hF, 0);
    idle(1);
    check("t2_vec1", 16'(bus.int_vec), 16'h0081);
    step(1, 0, 0, 4'hF, 0);
    step(0, 1, 0, 4'hF, 0);
    cur_irq = 8'h00;

    // Equal priority: lowest index first.
    cur_cp = 3'd0;
    cfg_write(4'h0, 16'h8005);
    cfg_write(4'h3, 16'h8005);
    cur_irq = 8'h09;
    idle(2);
    check("t3_vec0", 16'(bus.int_vec), 16'h0080);
    step(1, 0, 0, 4'hF, 0);
    step(0, 1, 0, 4'hF, 0);
    idle(1);
    check("t3_vec3", 16'(bus.int_vec), 16'h0083);
    step(1, 0, 0, 4'hF, 0);
    step(0, 1, 0, 4'hF, 0);
    cur_irq = 8'h00;

    // Withdrawal by cpu_prio, then re-arbitration.
    cur_cp = 3'd1;
    cfg_write(4'h4, 16'h8002);
    cur_irq = 8'h10;
    idle(2);
    check("t4_vec", 16'(bus.int_vec), 16'h0084);
    cur_cp = 3'd2;
    idle(1);
    check("t4_drop", 16'(bus.int_req), 16'h0);
    read_chk("t4_pend", 4'hE, 16'h0010);
    cur_cp = 3'd1;
    idle(1);
    check("t4_rereq", 16'(bus.int_req), 16'h1);
    check("t4_revec", 16'(bus.int_vec), 16'h0084);
    step(1, 0, 0, 4'hF, 0);
    step(0, 1, 0, 4'hF, 0);
    cur_irq = 8'h00;

    // Level-held line gives one request; W1C loses to a simultaneous edge.
    cur_cp = 3'd0;
    cfg_write(4'h6, 16'h8007);
    cur_irq = 8'h40;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      ack = m_req;
      if (ack) n_ack++;
      step(ack, 0, 0, 4'hE, 0);
    end
    check("t5_once", 16'(n_ack), 16'h1);
    cur_irq = 8'h00;
    step(0, 1, 0, 4'hF, 0);
    cur_irq = 8'h40;
    step(0, 0, 1, 4'hE, 16'h0040);
    read_chk("t5_collide", 4'hE, 16'h0040);
    idle(1);
    check("t5_req", 16'(bus.int_req), 16'h1);

    // Async reset while requesting.
    #2 rst = 1'b0;
    #1 check("t7_async", 16'(bus.int_req), 16'h0);
    read_chk("t7_status", 4'hF, 16'h0000);
    m_reset();
    cur_irq = 8'h00;
    bus.irq_in = 8'h00;
    @(negedge clk);
    rst = 1'b1;

    // Spurious controls on an idle controller.
    step(0, 1, 0, 4'hF, 0);
    step(1, 0, 0, 4'hF, 0);
    step(0, 0, 1, 4'h9, 16'hFFFF);
    read_chk("t6_status", 4'hF, 16'h0000);
    read_chk("t6_addr9", 4'h9, 16'h0000);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit [3:0]  addr;
      bit [15:0] wd;
      bit        we;
      cur_irq ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) cur_cp = 3'($urandom_range(0, 4));
      ack  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      we   = ($urandom_range(0, 4) == 0);
      addr = 4'($urandom_range(0, 15));
      wd   = 16'($urandom);
      wd[15] = ($urandom_range(0, 3) != 0);
      step(ack, $urandom_range(0, 7) == 0, we, addr, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
